q_bcd_reader: RTL

Sequential binary-to-BCD reader for the 10-bit `Q` result word produced by the datapath. It converts one sampled `Q` value into four packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. It sits between the datapath result register and the display logic, and is triggered by the same control that strobes `load` into the datapath.

---
 rtl/q_bcd_pkg.sv | 21 ++
 rtl/bcd_nibble_adj.sv | 12 +
 rtl/q_bcd_reader.sv | 113 +++++++++++
 3 files changed

// File: rtl/q_bcd_pkg.sv
// Shared types and defaults for the Q result-word BCD reader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package q_bcd_pkg;

  localparam int Q_W_DEF   = 10;
  localparam int N_DIG_DEF = 4;
  localparam int CNT_W     = $clog2(Q_W_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for an arbitrary word width, never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble digit correction: a nibble of 5 or more gets 3 added before the shift.
// Latency: combinational.
// Backpressure: none; pure function of the input nibble.
module bcd_nibble_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Inputs never exceed 9, so the 4-bit sum tops out at 12 and cannot carry.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/q_bcd_reader.sv
// Sequential binary-to-BCD reader for the datapath Q word (one bit per clock, shift-and-add-3).
// Latency: start accepted at E0, bcd/done update at E0+Q_W+1; busy high for Q_W+1 cycles.
// Backpressure: start is only taken while idle; requests during busy are dropped, not queued.
// Optional build macro Q_BCD_ZERO_BLANK_EN adds the registered leading-zero 'blank' output.
module q_bcd_reader
  import q_bcd_pkg::*;
#(
  parameter int Q_W   = Q_W_DEF,
  parameter int N_DIG = N_DIG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [Q_W-1:0]     q,
  output logic               busy,
  output logic               done,
  output logic [4*N_DIG-1:0] bcd
`ifdef Q_BCD_ZERO_BLANK_EN
  ,
  output logic [N_DIG-1:0]   blank
`endif
);

  localparam int CW = cnt_width(Q_W);
  localparam int SW = 4 * N_DIG;   // BCD scratch width
  localparam int RW = SW + Q_W;    // full {scratch, bin} shift register

  localparam logic [1:0]    S_IDLE   = IDLE;
  localparam logic [1:0]    S_SHIFT  = SHIFT;
  localparam logic [1:0]    S_DONE   = DONE;
  localparam logic [CW-1:0] CNT_LAST = CW'(Q_W - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] sr;
  logic [SW-1:0] adj;
  logic [RW-1:0] sr_shift;

  // One corrector per digit of the scratch area.
  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .din  (sr[Q_W + 4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  // Correct first, then shift the whole register one place towards the scratch.
  assign sr_shift = {adj, sr[Q_W-1:0]} << 1;

  assign busy = (state != S_IDLE);

  // Conversion FSM, shift register, bit counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      sr    <= '0;
      bcd   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sr    <= {{SW{1'b0}}, q};
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr  <= sr_shift;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          bcd   <= sr[RW-1:Q_W];
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef Q_BCD_ZERO_BLANK_EN
  logic [N_DIG-1:0] blank_nxt;
  logic             hi_zero;

  // A digit blanks only when it and everything above it is zero; ones never blanks.
  always_comb begin
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (sr[Q_W + 4*i +: 4] == 4'd0);
      blank_nxt[i] = hi_zero;
    end
  end

  // Blank flags are captured on the same edge as the digits they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= {{(N_DIG-1){1'b1}}, 1'b0};
    end else if (state == S_DONE) begin
      blank <= blank_nxt;
    end
  end
`endif

endmodule
